// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, default
// word width and the fetch FSM state type.
package rv_pkg;

  localparam int unsigned DEFAULT_WORD_SIZE = 32;
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Response buffer for the fetch stage: DEPTH entries of WIDTH bits,
// synchronous push/pop with a clear that empties it in one edge.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage has no reset; stale contents are never visible because
  // reads are qualified by count/empty, and leaving it unreset keeps it RAM-friendly.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // The fetch credit scheme must never let a response land in a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads, buffers responses
// and feeds if_id_reg. Optional macro IF_MISALIGN_TRAP_EN adds a misalign trap.
module fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned          WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter int unsigned          BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic                 imem_rsp_valid,
  input  logic [WORD_SIZE-1:0] imem_rsp_data,
  output logic [WORD_SIZE-1:0] instr,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 fetch_valid
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic                 fetch_misalign,
  output logic [WORD_SIZE-1:0] fetch_misalign_pc
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH+1);

  fetch_state_e         state_q, state_d;
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_SIZE-1:0] rsp_pc_q, rsp_pc_d;        // PC of the next response that will be kept
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [2*WORD_SIZE-1:0] fifo_rdata;
  logic [CNT_W:0]         in_flight;
  logic                   has_credit, accept, rsp_drop, rsp_push;
  logic [WORD_SIZE-1:0]   redirect_target;

`ifdef IF_MISALIGN_TRAP_EN
  logic                 misalign_q, misalign_d;
  logic [WORD_SIZE-1:0] misalign_pc_q, misalign_pc_d;
  logic                 redir_misaligned;

  assign redir_misaligned  = redirect && (redirect_pc[1:0] != 2'b00);
  assign redirect_target   = redirect_pc;
  assign fetch_misalign    = misalign_q;
  assign fetch_misalign_pc = misalign_pc_q;
`else
  assign redirect_target = redirect_pc & ~WORD_SIZE'(3);
`endif

  // Every request holds a buffer slot from issue until it is popped.
  assign in_flight  = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign has_credit = (in_flight < (CNT_W+1)'(BUF_DEPTH)) && !fifo_full;

  assign imem_req_valid = (state_q == ST_RUN) && has_credit && !redirect;
  assign imem_addr      = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_push       = imem_rsp_valid && (drop_cnt_q == '0);

  assign fifo_push = rsp_push && !redirect;
  assign fifo_pop  = !fifo_empty && !stall && !redirect;

  assign fetch_valid = !fifo_empty && !redirect;
  assign instr       = fetch_valid ? fifo_rdata[WORD_SIZE-1:0] : WORD_SIZE'(NOP_INSTR);
  assign pc          = fetch_valid ? fifo_rdata[2*WORD_SIZE-1:WORD_SIZE] : '0;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
`ifdef IF_MISALIGN_TRAP_EN
    if (redirect) state_d = redir_misaligned ? ST_HALT : ST_RUN;
`endif
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
    if (accept)   fetch_pc_d = fetch_pc_q + WORD_SIZE'(4);
    if (rsp_push) rsp_pc_d   = rsp_pc_q + WORD_SIZE'(4);
    if (rsp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    // Everything still in flight after this edge belongs to the squashed path.
    if (redirect) begin
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      drop_cnt_d = outstanding_d;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_comb begin
    misalign_d    = misalign_q;
    misalign_pc_d = misalign_pc_q;
    if (redirect) begin
      misalign_d = redir_misaligned;
      if (redir_misaligned) misalign_pc_d = redirect_pc;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_q    <= 1'b0;
      misalign_pc_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_q    <= misalign_d;
      misalign_pc_q <= misalign_pc_d;
`endif
    end
  end

  fetch_fifo #(
    .WIDTH(2*WORD_SIZE),
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .clear_i(redirect),
    .wdata_i({rsp_pc_q, imem_rsp_data}),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam int          W     = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         stall = 1'b0, redirect = 1'b0;
  logic [W-1:0] redirect_pc = '0;
  logic         imem_req_valid, imem_req_ready = 1'b0;
  logic [W-1:0] imem_addr;
  logic         imem_rsp_valid = 1'b0;
  logic [W-1:0] imem_rsp_data = '0;
  logic [W-1:0] instr, pc;
  logic         fetch_valid;
`ifdef IF_MISALIGN_TRAP_EN
  logic         fetch_misalign;
  logic [W-1:0] fetch_misalign_pc;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.WORD_SIZE(W), .RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr(instr), .pc(pc), .fetch_valid(fetch_valid)
`ifdef IF_MISALIGN_TRAP_EN
    , .fetch_misalign(fetch_misalign), .fetch_misalign_pc(fetch_misalign_pc)
`endif
  );

  // Memory requests in flight, tagged with the control-flow epoch that issued them.
  typedef struct {
    logic [W-1:0] addr;
    int           epoch;
    int           ready_cyc;
  } mreq_t;

  mreq_t        mem_q[$];
  logic [W-1:0] buf_q[$];     // PCs delivered and not yet consumed
  logic [W-1:0] acc_log[$];   // addresses the DUT had accepted
  logic [W-1:0] dlv_log[$];   // PCs the DUT handed to ID
  logic [W-1:0] issue_pc;
  int           epoch = 0, cyc = 0;
  bit           idle = 1'b1, halted = 1'b0, mis_flag = 1'b0;
  logic [W-1:0] mis_pc = '0;
  bit           last_fv;
  int           n_tests = 0, n_fail = 0;
  int           stall_pct = 0, ready_pct = 0, rsp_pct = 0, redir_pct = 0;
  bit           rand_target = 1'b0;
  logic [W-1:0] redir_target = '0;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc, 0);
    check("rst_fetch_valid", fetch_valid, 0);
`ifdef IF_MISALIGN_TRAP_EN
    check("rst_misalign", fetch_misalign, 0);
`endif
    mem_q.delete(); buf_q.delete();
    issue_pc = RST_PC; idle = 1'b1; halted = 1'b0; mis_flag = 1'b0; mis_pc = '0;
    epoch++;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // One clock: drive inputs at negedge, compare against the model, then advance the model at posedge.
  task automatic step();
    logic  exp_rv, exp_fv, acc;
    mreq_t h;
    @(negedge clk);
    stall          = roll(stall_pct);
    imem_req_ready = roll(ready_pct);
    redirect       = roll(redir_pct);
    if (rand_target)
      redir_target = ($urandom() & 32'hFFFF_FFFC) | (roll(20) ? 32'($urandom_range(3)) : 32'h0);
    redirect_pc    = redirect ? redir_target : $urandom();
    imem_rsp_valid = (mem_q.size() > 0) && (mem_q[0].ready_cyc <= cyc) && roll(rsp_pct);
    imem_rsp_data  = imem_rsp_valid ? mem_word(mem_q[0].addr) : $urandom();
    #1;
    exp_rv = !idle && !halted && (mem_q.size() + buf_q.size() < DEPTH) && !redirect;
    exp_fv = (buf_q.size() > 0) && !redirect;
    check("req_valid", imem_req_valid, exp_rv);
    check("imem_addr", imem_addr, issue_pc);
    check("fetch_valid", fetch_valid, exp_fv);
    check("pc", pc, exp_fv ? buf_q[0] : '0);
    check("instr", instr, exp_fv ? mem_word(buf_q[0]) : NOP);
`ifdef IF_MISALIGN_TRAP_EN
    check("misalign", fetch_misalign, mis_flag);
    check("misalign_pc", fetch_misalign_pc, mis_pc);
`endif
    last_fv = fetch_valid;
    if (imem_req_valid && imem_req_ready) acc_log.push_back(imem_addr);
    if (fetch_valid && !stall && !redirect) dlv_log.push_back(pc);
    acc = exp_rv && imem_req_ready;
    @(posedge clk);
    cyc++;
    idle = 1'b0;
    if (exp_fv && !stall) void'(buf_q.pop_front());
    if (imem_rsp_valid) begin
      h = mem_q.pop_front();
      if (h.epoch == epoch && !redirect) buf_q.push_back(h.addr);
    end
    if (acc) begin
      mem_q.push_back('{addr: issue_pc, epoch: epoch, ready_cyc: cyc});
      issue_pc = issue_pc + 32'd4;
    end
    if (redirect) begin
      epoch++;
      buf_q.delete();
`ifdef IF_MISALIGN_TRAP_EN
      issue_pc = redirect_pc;
      halted   = (redirect_pc[1:0] != 2'b00);
      mis_flag = halted;
      if (halted) mis_pc = redirect_pc;
`else
      issue_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
    end
  endtask

  task automatic set_knobs(input int s, input int r, input int p, input int d);
    stall_pct = s; ready_pct = r; rsp_pct = p; redir_pct = d;
  endtask

  task automatic one_redirect(input logic [W-1:0] tgt);
    int saved;
    saved = redir_pct;
    rand_target = 1'b0; redir_target = tgt; redir_pct = 100;
    step();
    redir_pct = saved;
  endtask

  initial begin
    int first;
    do_reset();

    // Streaming from reset: first instruction reaches ID three cycles after release.
    set_knobs(0, 100, 100, 0);
    acc_log.delete(); dlv_log.delete(); first = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_fv && first < 0) first = i;
    end
    check("t1_first_valid_cycle", 64'(first), 3);
    check("t1_addr0", acc_log[0], 32'h0);
    check("t1_addr1", acc_log[1], 32'h4);
    check("t1_addr2", acc_log[2], 32'h8);
    check("t1_dlv0", dlv_log[0], 32'h0);
    check("t1_dlv2", dlv_log[2], 32'h8);

    // Stall right after reset: only BUF_DEPTH requests may be issued.
    do_reset();
    acc_log.delete(); dlv_log.delete();
    set_knobs(100, 100, 100, 0);
    repeat (6) step();
    check("t2_credit_limit", acc_log.size(), DEPTH);
    set_knobs(0, 100, 100, 0);
    repeat (6) step();
    check("t2_order0", dlv_log[0], 32'h0);
    check("t2_order1", dlv_log[1], 32'h4);
    check("t2_order2", dlv_log[2], 32'h8);

    // Redirect with two requests in flight: both responses must be discarded.
    set_knobs(0, 100, 0, 0);
    repeat (4) step();
    check("t3_in_flight", mem_q.size(), 2);
    one_redirect(32'h0000_0100);
    set_knobs(0, 100, 100, 0);
    acc_log.delete(); dlv_log.delete();
    repeat (8) step();
    check("t3_first_addr", acc_log[0], 32'h100);
    check("t3_first_pc", dlv_log[0], 32'h100);

    // Memory back-pressure: address and valid must hold (model checks every cycle).
    set_knobs(0, 0, 100, 0);
    repeat (4) step();
    set_knobs(0, 100, 100, 0);
    repeat (4) step();

    // Address wrap at the top of the address space.
    one_redirect(32'hFFFF_FFFC);
    acc_log.delete();
    repeat (6) step();
    check("t6_wrap_a", acc_log[0], 32'hFFFF_FFFC);
    check("t6_wrap_b", acc_log[1], 32'h0000_0000);

`ifdef IF_MISALIGN_TRAP_EN
    one_redirect(32'h0000_0102);
    acc_log.delete();
    repeat (5) step();
    check("t6_halt_no_req", acc_log.size(), 0);
    check("t6_misalign_flag", fetch_misalign, 1);
    one_redirect(32'h0000_0200);
    acc_log.delete();
    repeat (5) step();
    check("t6_resume_addr", acc_log[0], 32'h200);
    check("t6_misalign_clear", fetch_misalign, 0);
`else
    one_redirect(32'h0000_0103);
    acc_log.delete();
    repeat (5) step();
    check("t6_forced_align", acc_log[0], 32'h100);
`endif

    // Randomized traffic with occasional reset mid-burst.
    rand_target = 1'b1;
    for (int r = 0; r < 4; r++) begin
      set_knobs(25 + 10 * r, 70, 60, 6);
      repeat (600) step();
      do_reset();
    end
    set_knobs(0, 100, 100, 0);
    rand_target = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
